instr_seq_fsm: RTL and testbench
================================

# instr_seq_fsm

Multicycle control sequencer driving the 2-bit `control` select of the 16-bit 4:1 operand mux feeding the ALU B input. It also drives the datapath enables for fetch, decode, execute, memory and writeback. The block steps one instruction at a time through a Moore state machine. The opcode is sampled from the instruction register during DECODE.

## Interface
- `OPW`, default 4: opcode width in bits.
- `clock`  in  1  system clock; all state updates on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `run`  in  1  level; while high, instructions are sequenced back-to-back.
- `opcode`  in  OPW  instruction opcode from the IR; valid only in DECODE.
- `control`  out  2  operand mux select:
  - 00 = register B
  - 01 = sign-extended immediate
  - 10 = constant 2 (PC increment)
  - 11 = shifted immediate
- `mem_read`, `mem_write`, `ir_write`, `pc_write`, `branch_en`, `reg_write`  out  1 each  datapath enables.
- `done`  out  1  one-cycle pulse in the final state of each instruction.
- `error`  out  1  sticky illegal-opcode flag.
- `state`  out  3  current state encoding, for debug.

## Operation
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6. Code 7 is unreachable; if entered, the next state is IDLE.
- Opcodes:
  - 0 = add
  - 1 = addi
  - 2 = lw
  - 3 = sw
  - 4 = beq
  - 5 = jump
  - 6..15 = illegal
- `op_q` register: loaded from `opcode` on the clock edge leaving DECODE. EXEC, MEM and WB decode from `op_q` only. `opcode` is ignored outside DECODE.
- Transitions:
  - IDLE → FETCH when `run`=1; otherwise stay in IDLE.
  - FETCH → DECODE, unconditionally.
  - DECODE → EXEC for opcodes 0–4; → instruction end for jump (5); → HALT for illegal opcodes.
  - EXEC → WB for add/addi; → MEM for lw/sw; → instruction end for beq.
  - MEM → WB for lw; → instruction end for sw.
  - WB → instruction end.
  - Instruction end: go to FETCH if `run`=1, else IDLE.
  - HALT: remains in HALT until reset.
- Outputs are a pure function of the current state and `op_q`; there is no combinational path from `run`. The one exception is DECODE, where `opcode` is used directly for `pc_write` and `done`.
- Output values by state (outputs not listed are 0):
  - IDLE: `control`=00.
  - FETCH: `control`=10, `mem_read`=1, `ir_write`=1, `pc_write`=1.
  - DECODE: `control`=11; `pc_write`=1 and `done`=1 iff `opcode`=5.
  - EXEC: `control`=00 for add/beq, 01 for addi/lw/sw; `branch_en`=1 iff beq; `done`=1 iff beq.
  - MEM: `control`=01; `mem_read`=1 for lw; `mem_write`=1 and `done`=1 for sw.
  - WB: `control`=00, `reg_write`=1, `done`=1.
  - HALT: `control`=00, `error`=1.
- At most one of `mem_read` and `mem_write` is high in any cycle.

## Timing
- Reset (`reset_n`=0, asynchronous):
  - state=IDLE, `op_q`=0.
  - All outputs 0, including `control`=00, `error`=0, `done`=0.
  - Reset asserted mid-instruction aborts immediately; no enable stays high after the asserting edge.
- Reset release: `run` is sampled on the first rising edge after deassertion.
- Latency from the edge where `run` is seen high to FETCH: 1 cycle.
- Cycles per instruction, counted from FETCH through the cycle where `done` pulses:
  - jump: 2
  - beq: 3
  - add, addi, sw: 4
  - lw: 5
  - illegal opcode: 2 cycles, then HALT; `done` never pulses.
- Back-to-back execution: with `run` held high, FETCH of the next instruction follows the `done` cycle with zero bubble.
- `run` dropped mid-instruction: the current instruction completes, then the FSM enters IDLE.
- `done` is high for exactly one cycle per completed instruction.
- `control` is stable for the whole cycle, so the downstream mux sees a glitch-free select at each edge.

## Test plan
- Reset: hold `reset_n`=0 with `run`=1 → `state`=0 and all outputs 0. Release → `state`=1 and `control`=10 after one edge.
- lw (opcode 2), `run` held high → state sequence 1,2,3,4,5,1. `control` sequence 10,11,01,01,00. `mem_read` high in FETCH and MEM. `reg_write` and `done` high only in WB.
- beq then jump, back-to-back → beq: states 1,2,3 with `branch_en`=1 and `done`=1 in EXEC. Jump: states 1,2 with `pc_write`=1 and `done`=1 in DECODE. No IDLE cycle between the two instructions.
- sw (opcode 3) with `run` dropped during EXEC → MEM has `mem_write`=1, `done`=1, `control`=01. The next state is IDLE (0).
- Opcode 9 in DECODE → HALT with `error`=1 and `done` never high. Toggling `run` has no effect. Reset clears `error`.
- Assert `reset_n`=0 mid-edge while in MEM of lw → all outputs go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/instr_seq_fsm.sv
// Multicycle instruction sequencer: steps one instruction through
// FETCH/DECODE/EXEC/MEM/WB and drives ALU operand select and datapath enables.
module instr_seq_fsm #(
    parameter int OPW = 4
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           run,
    input  logic [OPW-1:0] opcode,
    output logic [1:0]     control,
    output logic           mem_read,
    output logic           mem_write,
    output logic           ir_write,
    output logic           pc_write,
    output logic           branch_en,
    output logic           reg_write,
    output logic           done,
    output logic           error,
    output logic [2:0]     state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_BAD    = 3'd7
    } state_t;

    typedef struct packed {
        logic [1:0] control;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       branch_en;
        logic       reg_write;
        logic       done;
        logic       error;
    } outs_t;

    localparam logic [OPW-1:0] OP_ADD  = OPW'(0);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(1);
    localparam logic [OPW-1:0] OP_LW   = OPW'(2);
    localparam logic [OPW-1:0] OP_SW   = OPW'(3);
    localparam logic [OPW-1:0] OP_BEQ  = OPW'(4);
    localparam logic [OPW-1:0] OP_JMP  = OPW'(5);

    state_t         cur;
    state_t         nxt;
    logic [OPW-1:0] op_q;
    logic [OPW-1:0] nop;
    outs_t          o_q;
    logic           dec_jmp;

    function automatic outs_t outs_of(state_t s, logic [OPW-1:0] op);
        outs_t o;
        o = '0;
        unique case (s)
            S_FETCH: begin
                o.control  = 2'b10;
                o.mem_read = 1'b1;
                o.ir_write = 1'b1;
                o.pc_write = 1'b1;
            end
            S_DECODE: o.control = 2'b11;
            S_EXEC: begin
                o.control   = (op == OP_ADD || op == OP_BEQ) ? 2'b00 : 2'b01;
                o.branch_en = (op == OP_BEQ);
                o.done      = (op == OP_BEQ);
            end
            S_MEM: begin
                o.control   = 2'b01;
                o.mem_read  = (op == OP_LW);
                o.mem_write = (op == OP_SW);
                o.done      = (op == OP_SW);
            end
            S_WB: begin
                o.reg_write = 1'b1;
                o.done      = 1'b1;
            end
            S_HALT: o.error = 1'b1;
            default: o = '0;
        endcase
        return o;
    endfunction

    // Instruction end: chain straight into the next FETCH while run is high
    function automatic state_t next_of(state_t s, logic go,
                                       logic [OPW-1:0] opc,
                                       logic [OPW-1:0] op);
        state_t fin;
        state_t n;
        fin = go ? S_FETCH : S_IDLE;
        unique case (s)
            S_IDLE:   n = go ? S_FETCH : S_IDLE;
            S_FETCH:  n = S_DECODE;
            S_DECODE: begin
                if (opc < OP_JMP)
                    n = S_EXEC;
                else if (opc == OP_JMP)
                    n = fin;
                else
                    n = S_HALT;
            end
            S_EXEC: begin
                if (op == OP_ADD || op == OP_ADDI)
                    n = S_WB;
                else if (op == OP_LW || op == OP_SW)
                    n = S_MEM;
                else if (op == OP_BEQ)
                    n = fin;
                else
                    n = S_IDLE;
            end
            S_MEM: begin
                if (op == OP_LW)
                    n = S_WB;
                else if (op == OP_SW)
                    n = fin;
                else
                    n = S_IDLE;
            end
            S_WB:   n = fin;
            S_HALT: n = S_HALT;
            default: n = S_IDLE;
        endcase
        return n;
    endfunction

    assign nop = (cur == S_DECODE) ? opcode : op_q;
    assign nxt = next_of(cur, run, opcode, op_q);

    // Outputs are registered from the next state so they are glitch-free
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cur  <= S_IDLE;
            op_q <= '0;
            o_q  <= '0;
        end else begin
            cur  <= nxt;
            op_q <= nop;
            o_q  <= outs_of(nxt, nop);
        end
    end

    assign dec_jmp   = (cur == S_DECODE) && (opcode == OP_JMP);
    assign control   = o_q.control;
    assign mem_read  = o_q.mem_read;
    assign mem_write = o_q.mem_write;
    assign ir_write  = o_q.ir_write;
    assign pc_write  = o_q.pc_write | dec_jmp;
    assign branch_en = o_q.branch_en;
    assign reg_write = o_q.reg_write;
    assign done      = o_q.done | dec_jmp;
    assign error     = o_q.error;
    assign state     = cur;

endmodule

// File: tb/tb_instr_seq_fsm.sv
// Bench for instr_seq_fsm: directed vector table, hand-written reset
// corners, then random run/opcode traffic against an instruction-level model.
module tb_instr_seq_fsm;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       run;
    logic [3:0] opcode;
    logic [1:0] control;
    logic       mem_read, mem_write, ir_write, pc_write;
    logic       branch_en, reg_write, done, error;
    logic [2:0] state;

    int n_tests = 0;
    int n_fail  = 0;

    instr_seq_fsm #(.OPW(4)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .run       (run),
        .opcode    (opcode),
        .control   (control),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .ir_write  (ir_write),
        .pc_write  (pc_write),
        .branch_en (branch_en),
        .reg_write (reg_write),
        .done      (done),
        .error     (error),
        .state     (state)
    );

    always #5 clock = ~clock;

    // {state, control, mem_read, mem_write, ir_write, pc_write,
    //  branch_en, reg_write, done, error}
    typedef struct {
        logic       run;
        logic [3:0] opcode;
        logic [2:0] st;
        logic [9:0] outs;
    } vec_t;

    vec_t tbl[21];

    function automatic logic [12:0] actual();
        return {state, control, mem_read, mem_write, ir_write, pc_write,
                branch_en, reg_write, done, error};
    endfunction

    task automatic check(input string name, input logic [12:0] exp);
        logic [12:0] act;
        act = actual();
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got st=%0d outs=%b, expected st=%0d outs=%b",
                     name, act[12:10], act[9:0], exp[12:10], exp[9:0]);
        end
    endtask

    // Output table straight from the per-state output listing
    function automatic logic [9:0] spec_outs(int st, int op);
        case (st)
            1: return 10'b10_1011_0000;
            2: return (op == 5) ? 10'b11_0001_0010 : 10'b11_0000_0000;
            3: begin
                if (op == 0) return 10'b00_0000_0000;
                if (op == 4) return 10'b00_0000_1010;
                return 10'b01_0000_0000;
            end
            4: begin
                if (op == 2) return 10'b01_1000_0000;
                if (op == 3) return 10'b01_0100_0010;
                return 10'b01_0000_0000;
            end
            5: return 10'b00_0000_0110;
            6: return 10'b00_0000_0001;
            default: return 10'b0;
        endcase
    endfunction

    // Instruction-level model: mode 0 idle, 1 executing, 2 halted
    int m_mode = 0;
    int m_pos  = 0;
    int m_op   = 0;

    function automatic int ilen(int op);
        case (op)
            5: return 2;
            4: return 3;
            2: return 5;
            default: return 4;
        endcase
    endfunction

    function automatic int m_state();
        if (m_mode == 0) return 0;
        if (m_mode == 2) return 6;
        case (m_pos)
            0: return 1;
            1: return 2;
            2: return 3;
            3: return (m_op == 2 || m_op == 3) ? 4 : 5;
            default: return 5;
        endcase
    endfunction

    task automatic m_step(input logic r, input int opc);
        if (m_mode == 0) begin
            if (r) begin
                m_mode = 1;
                m_pos  = 0;
            end
        end else if (m_mode == 1) begin
            if (m_pos == 1) m_op = opc;
            if (m_pos == 1 && opc > 5) begin
                m_mode = 2;
            end else if (m_pos == ilen(m_op) - 1) begin
                if (r) m_pos = 0;
                else m_mode = 0;
            end else begin
                m_pos++;
            end
        end
    endtask

    task automatic apply(input vec_t v, input string name);
        run    = v.run;
        opcode = v.opcode;
        #2;
        check(name, {v.st, v.outs});
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input string name);
        reset_n = 1'b0;
        #1;
        check(name, 13'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        m_mode  = 0;
        m_pos   = 0;
        m_op    = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [12:0] exp;
        int          e_op;

        tbl[0]  = '{1'b1, 4'd0, 3'd0, 10'b00_0000_0000};
        tbl[1]  = '{1'b1, 4'd2, 3'd1, 10'b10_1011_0000};
        tbl[2]  = '{1'b1, 4'd2, 3'd2, 10'b11_0000_0000};
        tbl[3]  = '{1'b1, 4'd0, 3'd3, 10'b01_0000_0000};
        tbl[4]  = '{1'b1, 4'd0, 3'd4, 10'b01_1000_0000};
        tbl[5]  = '{1'b1, 4'd0, 3'd5, 10'b00_0000_0110};
        tbl[6]  = '{1'b1, 4'd0, 3'd1, 10'b10_1011_0000};
        tbl[7]  = '{1'b1, 4'd4, 3'd2, 10'b11_0000_0000};
        tbl[8]  = '{1'b1, 4'd0, 3'd3, 10'b00_0000_1010};
        tbl[9]  = '{1'b1, 4'd0, 3'd1, 10'b10_1011_0000};
        tbl[10] = '{1'b1, 4'd5, 3'd2, 10'b11_0001_0010};
        tbl[11] = '{1'b1, 4'd0, 3'd1, 10'b10_1011_0000};
        tbl[12] = '{1'b1, 4'd3, 3'd2, 10'b11_0000_0000};
        tbl[13] = '{1'b0, 4'd0, 3'd3, 10'b01_0000_0000};
        tbl[14] = '{1'b0, 4'd0, 3'd4, 10'b01_0100_0010};
        tbl[15] = '{1'b1, 4'd0, 3'd0, 10'b00_0000_0000};
        tbl[16] = '{1'b1, 4'd0, 3'd1, 10'b10_1011_0000};
        tbl[17] = '{1'b1, 4'd9, 3'd2, 10'b11_0000_0000};
        tbl[18] = '{1'b0, 4'd0, 3'd6, 10'b00_0000_0001};
        tbl[19] = '{1'b1, 4'd0, 3'd6, 10'b00_0000_0001};
        tbl[20] = '{1'b0, 4'd2, 3'd6, 10'b00_0000_0001};

        reset_n = 1'b0;
        run     = 1'b1;
        opcode  = 4'd0;
        repeat (2) @(posedge clock);
        #3;
        check("reset_hold", 13'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        for (int i = 0; i < 21; i++)
            apply(tbl[i], $sformatf("vec%0d", i));

        do_reset("reset_clears_error");

        // lw interrupted by an asynchronous reset while in MEM
        apply('{1'b1, 4'd0, 3'd0, 10'b00_0000_0000}, "lw_idle");
        apply('{1'b1, 4'd0, 3'd1, 10'b10_1011_0000}, "lw_fetch");
        apply('{1'b1, 4'd2, 3'd2, 10'b11_0000_0000}, "lw_decode");
        apply('{1'b1, 4'd0, 3'd3, 10'b01_0000_0000}, "lw_exec");
        #2;
        check("lw_mem", {3'd4, 10'b01_1000_0000});
        do_reset("mid_mem_reset");

        for (int c = 0; c < 3000; c++) begin
            run = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0)
                opcode = 4'($urandom_range(6, 15));
            else
                opcode = 4'($urandom_range(0, 5));
            #2;
            e_op = (m_mode == 1 && m_pos == 1) ? int'(opcode) : m_op;
            exp  = {3'(m_state()), spec_outs(m_state(), e_op)};
            check("rand", exp);
            if ((m_mode == 2 && $urandom_range(0, 3) == 0) ||
                $urandom_range(0, 199) == 0) begin
                do_reset("rand_reset");
            end else begin
                @(posedge clock);
                m_step(run, int'(opcode));
                #1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
